// File: rtl/wash_pkg.sv
// Shared definitions for the wash cycle sequencer.
//   SEC_W    : width of the seconds counter and of sec_left
//   phase_e  : phase encoding presented on the phase output
//   DEF_*    : default phase durations in seconds
package wash_pkg;

  localparam int unsigned SEC_W = 10;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

  localparam int unsigned DEF_FILL_SEC  = 120;
  localparam int unsigned DEF_WASH_SEC  = 300;
  localparam int unsigned DEF_RINSE_SEC = 120;
  localparam int unsigned DEF_SPIN_SEC  = 60;

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: emits a one-cycle tick every (SEC_DIV_BASE << div_sel) cycles.
//   clk, rst : clock and synchronous active-high reset
//   clr      : restart the prescaler from zero (phase entry / idle)
//   hold     : freeze the prescaler and suppress the tick
//   div_sel  : prescale select, divisor = SEC_DIV_BASE << div_sel
//   tick     : single-cycle pulse on the last cycle of each second
module sec_tick_gen #(
  parameter int unsigned SEC_DIV_BASE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  logic [1:0] div_sel,
  output logic       tick
);

  // One spare bit so the largest divisor (base << 3) is representable.
  localparam int unsigned PRE_W = $clog2(SEC_DIV_BASE << 3) + 1;

  logic [PRE_W-1:0] div_m1;
  logic [PRE_W-1:0] pre_q, pre_d;

  assign div_m1 = (PRE_W'(SEC_DIV_BASE) << div_sel) - PRE_W'(1);
  assign tick   = !hold && (pre_q == div_m1);

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (!hold) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Phase sequencer for one washing-machine channel: FILL, WASH, RINSE (optionally
// WASH+RINSE again), SPIN, each timed in seconds from a prescaled clock.
//   clk, rst    : clock and synchronous active-high reset
//   clk_freq    : prescale select, latched when a coin is accepted
//   coin_in     : start request, only honoured in IDLE
//   double_wash : extra WASH+RINSE pass, latched when a coin is accepted
//   timer_pause : freezes timing, only honoured in SPIN
//   phase       : current phase (IDLE/FILL/WASH/RINSE/SPIN)
//   phase_start : pulse on the first cycle of every non-IDLE phase
//   sec_left    : seconds remaining in the current phase, 0 in IDLE
//   busy        : phase is not IDLE
//   wash_done   : pulse on the first IDLE cycle after SPIN completes
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned SEC_DIV_BASE = 1_000_000,
  parameter int unsigned FILL_SEC     = DEF_FILL_SEC,
  parameter int unsigned WASH_SEC     = DEF_WASH_SEC,
  parameter int unsigned RINSE_SEC    = DEF_RINSE_SEC,
  parameter int unsigned SPIN_SEC     = DEF_SPIN_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       clk_freq,
  input  logic             coin_in,
  input  logic             double_wash,
  input  logic             timer_pause,
  output logic [2:0]       phase,
  output logic             phase_start,
  output logic [SEC_W-1:0] sec_left,
  output logic             busy,
  output logic             wash_done
);

  phase_e           phase_q, phase_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [SEC_W-1:0] left_q, left_d;
  logic [1:0]       freq_q, freq_d;
  logic             dbl_q, dbl_d;
  logic             pass_q, pass_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             tick, hold, clr, phase_end;
  logic [SEC_W-1:0] dur_cur;

  function automatic logic [SEC_W-1:0] dur_of(input phase_e ph);
    case (ph)
      PH_FILL:  return SEC_W'(FILL_SEC);
      PH_WASH:  return SEC_W'(WASH_SEC);
      PH_RINSE: return SEC_W'(RINSE_SEC);
      PH_SPIN:  return SEC_W'(SPIN_SEC);
      default:  return '0;
    endcase
  endfunction

  assign hold      = timer_pause && (phase_q == PH_SPIN);
  assign dur_cur   = dur_of(phase_q);
  assign phase_end = tick && (sec_q == dur_cur - 1'b1);
  // Prescaler sits at zero in IDLE and restarts on every phase change.
  assign clr       = (phase_q == PH_IDLE) || phase_end;

  sec_tick_gen #(
    .SEC_DIV_BASE(SEC_DIV_BASE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .hold   (hold),
    .div_sel(freq_q),
    .tick   (tick)
  );

  always_comb begin
    phase_d = phase_q;
    sec_d   = sec_q;
    freq_d  = freq_q;
    dbl_d   = dbl_q;
    pass_d  = pass_q;
    start_d = 1'b0;
    done_d  = 1'b0;

    if (phase_q == PH_IDLE) begin
      sec_d = '0;
      if (coin_in) begin
        phase_d = PH_FILL;
        freq_d  = clk_freq;
        dbl_d   = double_wash;
        pass_d  = 1'b0;
        start_d = 1'b1;
      end
    end else if (phase_end) begin
      sec_d   = '0;
      start_d = 1'b1;
      case (phase_q)
        PH_FILL: phase_d = PH_WASH;
        PH_WASH: phase_d = PH_RINSE;
        PH_RINSE: begin
          if (dbl_q && !pass_q) begin
            phase_d = PH_WASH;
            pass_d  = 1'b1;
          end else begin
            phase_d = PH_SPIN;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          start_d = 1'b0;
          done_d  = 1'b1;
        end
      endcase
    end else if (tick) begin
      sec_d = sec_q + 1'b1;
    end

    left_d = (phase_d == PH_IDLE) ? '0 : dur_of(phase_d) - sec_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      sec_q   <= '0;
      left_q  <= '0;
      freq_q  <= '0;
      dbl_q   <= 1'b0;
      pass_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sec_q   <= sec_d;
      left_q  <= left_d;
      freq_q  <= freq_d;
      dbl_q   <= dbl_d;
      pass_q  <= pass_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign phase       = phase_q;
  assign phase_start = start_q;
  assign sec_left    = left_q;
  assign busy        = (phase_q != PH_IDLE);
  assign wash_done   = done_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
module tb_wash_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clk_freq;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic [2:0] phase;
  logic       phase_start;
  logic [9:0] sec_left;
  logic       busy;
  logic       wash_done;

  wash_cycle_sequencer #(
    .SEC_DIV_BASE(2),
    .FILL_SEC    (2),
    .WASH_SEC    (3),
    .RINSE_SEC   (2),
    .SPIN_SEC    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_freq   (clk_freq),
    .coin_in    (coin_in),
    .double_wash(double_wash),
    .timer_pause(timer_pause),
    .phase      (phase),
    .phase_start(phase_start),
    .sec_left   (sec_left),
    .busy       (busy),
    .wash_done  (wash_done)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; outputs are sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ph;
    int sl;
    bit st;
    bit dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   pat[1024];
  int   checks = 0;
  int   errors = 0;
  int   last_done_cyc = -1;
  int   dur_tab[5] = '{0, 2, 3, 2, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Reference model: a phase lasts until it has seen dur*div unpaused cycles, where
  // only SPIN cycles can be paused. sec_left = dur - whole seconds already elapsed.
  task automatic build_model(input int s0, input int f, input bit dbl, output int e);
    int   seq[$];
    int   div, c, ph, d, act;
    bit   first;
    exp_t ent;
    seq = '{1, 2, 3};
    if (dbl) begin
      seq.push_back(2);
      seq.push_back(3);
    end
    seq.push_back(4);
    div = 2 << f;
    c   = s0;
    foreach (seq[i]) begin
      ph    = seq[i];
      d     = dur_tab[ph];
      act   = 0;
      first = 1'b1;
      while (act < d * div) begin
        ent = '{cyc: c, ph: ph, sl: d - act / div, st: first, dn: 1'b0};
        exp_q.push_back(ent);
        if (!(ph == 4 && pat[c - s0])) act++;
        c++;
        first = 1'b0;
      end
    end
    ent = '{cyc: c, ph: 0, sl: 0, st: 1'b0, dn: 1'b1};
    exp_q.push_back(ent);
    e = c;
  endtask

  // Monitor: pops an expectation whenever the DUT shows activity or one is due.
  always @(negedge clk) begin
    if (wash_done === 1'b1) last_done_cyc = cyc;
    if (exp_q.size() > 0 && (busy === 1'b1 || wash_done === 1'b1 || phase_start === 1'b1 ||
                             exp_q[0].cyc <= cyc)) begin
      mon_e = exp_q.pop_front();
      check("cycle", cyc, mon_e.cyc);
      check("phase", phase, mon_e.ph);
      check("sec_left", sec_left, mon_e.sl);
      check("phase_start", phase_start, mon_e.st);
      check("wash_done", wash_done, mon_e.dn);
      check("busy", busy, mon_e.ph != 0);
    end else if (busy === 1'b1 || wash_done === 1'b1 || phase_start === 1'b1) begin
      check("unexpected_activity", {busy, wash_done, phase_start}, 0);
    end
  end

  task automatic fill_pat(input int mode);
    for (int i = 0; i < 1024; i++) begin
      case (mode)
        1:       pat[i] = ($urandom_range(2) == 0);
        2:       pat[i] = (i >= 14 && i < 19);
        3:       pat[i] = (i < 14);
        default: pat[i] = 1'b0;
      endcase
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // One full wash; returns the wash_done cycle relative to the coin's drive cycle.
  task automatic run_wash(input int f, input bit dbl, input int mode, input int coin_off,
                          output int done_off);
    int c0, s0, e;
    fill_pat(mode);
    last_done_cyc = -1;
    @(negedge clk);
    c0 = cyc;
    s0 = c0 + 1;
    clk_freq = f[1:0];
    double_wash = dbl;
    coin_in = 1'b1;
    timer_pause = 1'b0;
    build_model(s0, f, dbl, e);
    @(negedge clk);
    while (cyc < e) begin
      timer_pause = pat[cyc - s0];
      coin_in     = (cyc - s0 == coin_off);
      clk_freq    = 2'($urandom_range(3));
      double_wash = 1'($urandom_range(1));
      @(negedge clk);
    end
    timer_pause = 1'b0;
    coin_in     = 1'b0;
    clk_freq    = 2'd0;
    double_wash = 1'b0;
    drain("drain");
    done_off = last_done_cyc - c0;
  endtask

  task automatic run_reset();
    int c0, e, r;
    fill_pat(0);
    @(negedge clk);
    c0 = cyc;
    r  = c0 + 8;
    coin_in = 1'b1;
    build_model(c0 + 1, 0, 1'b0, e);
    while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > r) void'(exp_q.pop_back());
    @(negedge clk);
    coin_in = 1'b0;
    while (cyc < r) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_phase", phase, 0);
    check("rst_busy", busy, 0);
    check("rst_sec_left", sec_left, 0);
    check("rst_phase_start", phase_start, 0);
    check("rst_wash_done", wash_done, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_left_queue", exp_q.size(), 0);
  endtask

  initial begin
    int d;
    rst = 1'b1;
    clk_freq = 2'd0;
    coin_in = 1'b0;
    double_wash = 1'b0;
    timer_pause = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_phase", phase, 0);
    check("reset_busy", busy, 0);
    check("reset_sec_left", sec_left, 0);
    check("reset_phase_start", phase_start, 0);
    check("reset_wash_done", wash_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_wash(0, 1'b0, 0, -1, d);
    check("single_done_offset", d, 17);
    run_wash(0, 1'b1, 0, -1, d);
    check("double_done_offset", d, 27);
    run_wash(2, 1'b0, 0, -1, d);
    check("prescale_done_offset", d, 65);
    run_wash(0, 1'b0, 2, -1, d);
    check("spin_pause_done_offset", d, 22);
    run_wash(0, 1'b0, 3, -1, d);
    check("early_pause_done_offset", d, 17);
    run_wash(0, 1'b0, 0, 2, d);
    check("busy_coin_done_offset", d, 17);

    run_reset();
    run_wash(0, 1'b0, 0, -1, d);
    check("post_reset_done_offset", d, 17);

    for (int i = 0; i < 16; i++) begin
      run_wash($urandom_range(3), 1'($urandom_range(1)), 1, $urandom_range(1, 8), d);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cyc %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
